// File: rtl/farm_sensor_pkg.sv
// Shared encodings for the farm-road request path and the traffic-light controller.
// Holds FSM state codes, farm-light codes and the green decode helper.
package farm_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    REQUEST = 2'd2,
    SERVED  = 2'd3
  } fsm_state_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Only the exact green code counts; illegal codes are treated as not green.
  function automatic logic is_green(input logic [2:0] light);
    return light == LIGHT_GRN;
  endfunction

endpackage

// File: rtl/sensor_sync_debounce.sv
// Two-flop synchroniser plus consecutive-disagreement debounce of the raw vehicle sensor.
// Latency 2+DB_CYCLES clk from a clean raw edge to sensor_db; no backpressure.
module sensor_sync_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_raw,
  output logic sensor_db
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s_meta_q;
  logic          s_sync_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] db_cnt_q;
  logic [CW-1:0] db_cnt_d;

  // The counter only runs while the synchronised level disagrees with the held level.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (s_sync_q != db_q) begin
      if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d = s_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q <= 1'b0;
      s_sync_q <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s_meta_q <= sensor_raw;
      s_sync_q <= s_meta_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign sensor_db = db_q;

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Qualifies the debounced farm sensor into request C, latched until farm green; counts arrivals.
// C rises (MIN_PRESENCE-1)*TICK_DIV+1..MIN_PRESENCE*TICK_DIV clk after QUALIFY entry; no backpressure.
module farm_sensor_conditioner
  import farm_sensor_pkg::*;
#(
  parameter int TICK_DIV     = 4,
  parameter int DB_CYCLES    = 3,
  parameter int MIN_PRESENCE = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic [2:0]       light_farm,
  input  logic             cnt_clr,
  output logic             C,
  output logic             sensor_db,
  output logic [CNT_W-1:0] vehicle_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int QW = (MIN_PRESENCE > 1) ? $clog2(MIN_PRESENCE) : 1;

  logic             db_prev_q;
  logic             db_rise;
  logic             farm_green;
  logic             tick;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic [QW-1:0]    q_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             c_q;
  fsm_state_e       state_q;

  sensor_sync_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_sync_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (sensor_raw),
    .sensor_db  (sensor_db)
  );

  assign db_rise    = sensor_db & ~db_prev_q;
  assign farm_green = is_green(light_farm);
  assign tick       = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d      = tick ? '0 : pre_q + PW'(1);

  // Clear takes priority over a same-cycle arrival; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (db_rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pre_q     <= pre_d;
      db_prev_q <= sensor_db;
      cnt_q     <= cnt_d;
    end
  end

  // A vehicle leaving during QUALIFY beats a coinciding qualifying tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_cnt_q <= '0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (db_rise) begin
            state_q <= QUALIFY;
            q_cnt_q <= '0;
          end
        end
        QUALIFY: begin
          if (!sensor_db) begin
            state_q <= IDLE;
          end else if (tick) begin
            if (q_cnt_q == QW'(MIN_PRESENCE - 1)) begin
              state_q <= REQUEST;
              c_q     <= 1'b1;
            end else begin
              q_cnt_q <= q_cnt_q + QW'(1);
            end
          end
        end
        REQUEST: begin
          if (farm_green) begin
            state_q <= SERVED;
            c_q     <= 1'b0;
          end
        end
        SERVED: begin
          if (!farm_green) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          c_q     <= 1'b0;
        end
      endcase
    end
  end

  assign C             = c_q;
  assign vehicle_count = cnt_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Directed, table-driven and randomized checks of farm_sensor_conditioner.
// Random phase compares every cycle against a window-based reference model.
module tb_farm_sensor_conditioner;
  import farm_sensor_pkg::*;

  localparam int TICK_DIV     = 4;
  localparam int DB_CYCLES    = 3;
  localparam int MIN_PRESENCE = 2;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int RND_CYCLES   = 4000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sensor_raw = 1'b0;
  logic [2:0]       light_farm = 3'b100;
  logic             cnt_clr = 1'b0;
  logic             C;
  logic             sensor_db;
  logic [CNT_W-1:0] vehicle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  int k;
  bit c_seen, db_seen;

  typedef struct {
    int len;
    bit db_seen;
    bit c_seen;
    int inc;
  } pulse_vec_t;
  pulse_vec_t pv[5];

  // Reference model state
  bit raw_hist[0:RND_CYCLES];
  bit m_db, m_db_prev, m_req, m_served, m_qual, all_diff, m_rise;
  int m_ticks, m_cnt, raw_hold, light_hold;

  farm_sensor_conditioner #(
    .TICK_DIV     (TICK_DIV),
    .DB_CYCLES    (DB_CYCLES),
    .MIN_PRESENCE (MIN_PRESENCE),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor_raw    (sensor_raw),
    .light_farm    (light_farm),
    .cnt_clr       (cnt_clr),
    .C             (C),
    .sensor_db     (sensor_db),
    .vehicle_count (vehicle_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_c(input int budget);
    int w;
    w = 0;
    while (C !== 1'b1 && w < budget) begin
      cyc();
      w++;
    end
  endtask

  task automatic serve();
    light_farm = LIGHT_GRN;
    cyc(2);
    light_farm = LIGHT_RED;
    cyc(2);
  endtask

  function automatic bit raw_at(input int idx);
    return (idx < 1) ? 1'b0 : raw_hist[idx];
  endfunction

  initial begin
    pv[0] = '{1,  1'b0, 1'b0, 0};
    pv[1] = '{2,  1'b0, 1'b0, 0};
    pv[2] = '{3,  1'b1, 1'b0, 1};
    pv[3] = '{5,  1'b1, 1'b0, 1};
    pv[4] = '{20, 1'b1, 1'b1, 1};

    // Reset held with the sensor active
    rst_n = 1'b0; sensor_raw = 1'b1; light_farm = LIGHT_RED;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rst_C", C, 0);
      check("rst_db", sensor_db, 0);
      check("rst_count", vehicle_count, 0);
    end
    rst_n = 1'b1;
    cyc(4);
    check("db_latency_4", sensor_db, 0);
    cyc();
    check("db_latency_5", sensor_db, 1);

    // Steady presence qualifies, green serves, steady level does not re-request
    k = 0;
    while (C !== 1'b1 && k < 12) begin
      cyc();
      k++;
    end
    check_range("c_rise_delay", k, 6, 9);
    exp_count = 1;
    check("count_first", vehicle_count, exp_count);
    cyc(3);
    check("c_latched_red", C, 1);
    light_farm = LIGHT_GRN;
    cyc();
    check("c_drop_green", C, 0);
    cyc(3);
    check("c_low_served", C, 0);
    light_farm = LIGHT_RED;
    c_seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      c_seen |= C;
    end
    check("no_requal_steady", c_seen, 0);

    // Vehicle leaves after request: C stays latched
    sensor_raw = 1'b0;
    cyc(10);
    sensor_raw = 1'b1;
    wait_c(20);
    check("c_rise_second", C, 1);
    exp_count++;
    sensor_raw = 1'b0;
    cyc(15);
    check("c_latched_leave", C, 1);
    serve();
    check("c_after_serve", C, 0);

    // Vehicle leaves during QUALIFY: no request
    sensor_raw = 1'b1;
    cyc(4);
    sensor_raw = 1'b0;
    c_seen = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      c_seen |= C;
    end
    check("qualify_abort", c_seen, 0);
    exp_count++;
    check("count_abort", vehicle_count, exp_count);

    // Pulse-length table: glitch rejection and qualification
    for (int r = 0; r < 5; r++) begin
      db_seen = 0;
      c_seen = 0;
      sensor_raw = 1'b1;
      for (int i = 0; i < pv[r].len + 15; i++) begin
        if (i == pv[r].len) sensor_raw = 1'b0;
        cyc();
        db_seen |= sensor_db;
        c_seen  |= C;
      end
      exp_count += pv[r].inc;
      check($sformatf("pulse%0d_db", pv[r].len), db_seen, pv[r].db_seen);
      check($sformatf("pulse%0d_C", pv[r].len), c_seen, pv[r].c_seen);
      check($sformatf("pulse%0d_count", pv[r].len), vehicle_count, exp_count);
      serve();
    end

    // Saturation and clear
    for (int i = 0; i < 300; i++) begin
      sensor_raw = 1'b1;
      cyc(10);
      sensor_raw = 1'b0;
      cyc(10);
    end
    check("count_saturate", vehicle_count, CNT_MAX);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check("count_clear", vehicle_count, 0);
    sensor_raw = 1'b1;
    cyc(5);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check("clr_wins", vehicle_count, 0);
    sensor_raw = 1'b0;
    cyc(10);
    sensor_raw = 1'b1;
    cyc(10);
    sensor_raw = 1'b0;
    cyc(10);
    check("count_after_clr", vehicle_count, 1);

    // Asynchronous reset while requesting
    serve();
    cyc(10);
    sensor_raw = 1'b1;
    wait_c(30);
    check("c_before_reset", C, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_C", C, 0);
    check("async_rst_db", sensor_db, 0);
    check("async_rst_count", vehicle_count, 0);
    @(posedge clk);
    #1;
    sensor_raw = 1'b0;
    rst_n = 1'b1;
    c_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      c_seen |= C;
    end
    check("no_request_after_rst", c_seen, 0);

    // Randomized run against the reference model
    rst_n = 1'b0; sensor_raw = 1'b0; cnt_clr = 1'b0; light_farm = LIGHT_RED;
    cyc(2);
    rst_n = 1'b1;
    m_db = 0; m_db_prev = 0; m_req = 0; m_served = 0; m_qual = 0;
    m_ticks = 0; m_cnt = 0; raw_hold = 0; light_hold = 0;
    for (int e = 1; e <= RND_CYCLES; e++) begin
      if (raw_hold == 0) begin
        sensor_raw = ~sensor_raw;
        raw_hold = $urandom_range(1, 25);
      end
      raw_hold--;
      if (light_hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: light_farm = LIGHT_GRN;
          4, 5, 6, 7: light_farm = LIGHT_RED;
          default:    light_farm = 3'($urandom_range(0, 7));
        endcase
        light_hold = $urandom_range(5, 30);
      end
      light_hold--;
      cnt_clr = ($urandom_range(0, 99) == 0);
      raw_hist[e] = sensor_raw;

      m_rise = m_db && !m_db_prev;
      if (m_req) begin
        if (light_farm == 3'b001) begin
          m_req = 0;
          m_served = 1;
        end
      end else if (m_served) begin
        if (light_farm != 3'b001) m_served = 0;
      end else if (m_qual) begin
        if (!m_db) begin
          m_qual = 0;
        end else if (e % TICK_DIV == 0) begin
          m_ticks++;
          if (m_ticks == MIN_PRESENCE) begin
            m_qual = 0;
            m_req = 1;
          end
        end
      end else if (m_rise) begin
        m_qual = 1;
        m_ticks = 0;
      end
      if (cnt_clr) m_cnt = 0;
      else if (m_rise && m_cnt < CNT_MAX) m_cnt++;
      // Debounced level flips once the last DB_CYCLES synchronised samples all disagree
      all_diff = 1;
      for (int j = 2; j <= DB_CYCLES + 1; j++) begin
        if (raw_at(e - j) == m_db) all_diff = 0;
      end
      m_db_prev = m_db;
      if (all_diff) m_db = ~m_db;

      cyc();
      check("rnd_C", C, m_req);
      check("rnd_db", sensor_db, m_db);
      check("rnd_count", vehicle_count, m_cnt);
    end
    cnt_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
